setpoint_editor: RTL and testbench

Three-button setpoint editor for the greenhouse controller. It consumes the one-cycle click pulses from the per-button debouncers (mode, up, down) and steps through a small edit menu for the temperature and humidity setpoints. It holds the committed setpoints that feed the climate control logic. Edits are staged in working registers and only committed on an explicit menu exit; abandoned edits time out.

---
 rtl/greenhouse_pkg.sv | 15 +
 rtl/setpoint_step.sv | 26 ++
 rtl/setpoint_editor.sv | 151 +++++++++++++++
 tb/tb_setpoint_editor.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/greenhouse_pkg.sv
// Shared types for the greenhouse setpoint editor: FSM state encoding and
// the edit_field codes presented to the display logic.
package greenhouse_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EDIT_TEMP = 2'd1,
        EDIT_HUM  = 2'd2
    } state_e;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_TEMP = 2'd1;
    localparam logic [1:0] FIELD_HUM  = 2'd2;

endpackage

// File: rtl/setpoint_step.sv
// Combinational saturating +/-1 stepper. Holds the value when both or neither
// of inc/dec are set; works in 9 bits so the bound compares cannot overflow.
module setpoint_step (
    input  logic [7:0] value,
    input  logic       inc,
    input  logic       dec,
    input  logic [7:0] min,
    input  logic [7:0] max,
    output logic [7:0] next
);

    logic [8:0] value_w;
    logic [8:0] next_w;

    always_comb begin
        value_w = {1'b0, value};
        next_w  = value_w;
        if (inc && !dec) begin
            next_w = (value_w >= {1'b0, max}) ? {1'b0, max} : value_w + 9'd1;
        end else if (dec && !inc) begin
            next_w = (value_w <= {1'b0, min}) ? {1'b0, min} : value_w - 9'd1;
        end
        next = next_w[7:0];
    end

endmodule

// File: rtl/setpoint_editor.sv
// Three-button temperature/humidity setpoint editor with staged edits and an
// idle timeout. Define SETPOINT_AUTOCOMMIT_EN to commit (not discard) on timeout.
module setpoint_editor
    import greenhouse_pkg::*;
#(
    parameter logic [7:0]  TEMP_MIN     = 8'd10,
    parameter logic [7:0]  TEMP_MAX     = 8'd40,
    parameter logic [7:0]  TEMP_DEFAULT = 8'd24,
    parameter logic [7:0]  HUM_MIN      = 8'd20,
    parameter logic [7:0]  HUM_MAX      = 8'd90,
    parameter logic [7:0]  HUM_DEFAULT  = 8'd60,
    parameter logic [31:0] TIMEOUT      = 32'd500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_click,
    input  logic       up_click,
    input  logic       down_click,
    output logic [7:0] temp_setpoint,
    output logic [7:0] hum_setpoint,
    output logic [7:0] edit_value,
    output logic [1:0] edit_field,
    output logic       update_strobe
);

    state_e      state_q, state_d;
    logic [7:0]  work_temp_q, work_temp_d;
    logic [7:0]  work_hum_q, work_hum_d;
    logic [7:0]  temp_q, temp_d;
    logic [7:0]  hum_q, hum_d;
    logic        strobe_q, strobe_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  value_q, value_d;
    logic [1:0]  field_q, field_d;

    logic       any_click;
    logic       commit;
    logic [7:0] temp_step, hum_step;

    assign any_click = mode_click | up_click | down_click;

    // mode wins over a coincident up/down, so the steppers are gated by it
    setpoint_step u_temp_step (
        .value (work_temp_q),
        .inc   (up_click   & ~mode_click & (state_q == EDIT_TEMP)),
        .dec   (down_click & ~mode_click & (state_q == EDIT_TEMP)),
        .min   (TEMP_MIN),
        .max   (TEMP_MAX),
        .next  (temp_step)
    );

    setpoint_step u_hum_step (
        .value (work_hum_q),
        .inc   (up_click   & ~mode_click & (state_q == EDIT_HUM)),
        .dec   (down_click & ~mode_click & (state_q == EDIT_HUM)),
        .min   (HUM_MIN),
        .max   (HUM_MAX),
        .next  (hum_step)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        work_temp_d = work_temp_q;
        work_hum_d  = work_hum_q;
        temp_d      = temp_q;
        hum_d       = hum_q;
        strobe_d    = 1'b0;
        cnt_d       = cnt_q;
        commit      = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mode_click) begin
                    work_temp_d = temp_q;
                    work_hum_d  = hum_q;
                    state_d     = EDIT_TEMP;
                end
            end
            EDIT_TEMP, EDIT_HUM: begin
                cnt_d = any_click ? '0 : cnt_q + 32'd1;
                if (mode_click) begin
                    if (state_q == EDIT_TEMP) begin
                        state_d = EDIT_HUM;
                    end else begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (any_click) begin
                    work_temp_d = temp_step;
                    work_hum_d  = hum_step;
                end else if (cnt_q == TIMEOUT - 32'd1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef SETPOINT_AUTOCOMMIT_EN
                    commit  = 1'b1;
`else
                    commit  = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            temp_d   = work_temp_q;
            hum_d    = work_hum_q;
            strobe_d = 1'b1;
        end

        // display outputs are registered from the next state so they track clicks with one edge of latency
        case (state_d)
            EDIT_TEMP: begin field_d = FIELD_TEMP; value_d = work_temp_d; end
            EDIT_HUM:  begin field_d = FIELD_HUM;  value_d = work_hum_d;  end
            default:   begin field_d = FIELD_NONE; value_d = 8'd0;        end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_temp_q <= TEMP_DEFAULT;
            work_hum_q  <= HUM_DEFAULT;
            temp_q      <= TEMP_DEFAULT;
            hum_q       <= HUM_DEFAULT;
            strobe_q    <= 1'b0;
            cnt_q       <= '0;
            value_q     <= 8'd0;
            field_q     <= FIELD_NONE;
        end else begin
            state_q     <= state_d;
            work_temp_q <= work_temp_d;
            work_hum_q  <= work_hum_d;
            temp_q      <= temp_d;
            hum_q       <= hum_d;
            strobe_q    <= strobe_d;
            cnt_q       <= cnt_d;
            value_q     <= value_d;
            field_q     <= field_d;
        end
    end

    assign temp_setpoint = temp_q;
    assign hum_setpoint  = hum_q;
    assign edit_value    = value_q;
    assign edit_field    = field_q;
    assign update_strobe = strobe_q;

endmodule

// File: tb/tb_setpoint_editor.sv
// Directed bench for setpoint_editor with a behavioural model feeding a scoreboard queue;
// runs with TIMEOUT=16 and follows SETPOINT_AUTOCOMMIT_EN for the timeout outcome.
module tb_setpoint_editor;

    localparam int TO = 16;
`ifdef SETPOINT_AUTOCOMMIT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       mode_click, up_click, down_click;
    logic [7:0] temp_setpoint, hum_setpoint, edit_value;
    logic [1:0] edit_field;
    logic       update_strobe;

    setpoint_editor #(.TIMEOUT(32'd16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode_click    (mode_click),
        .up_click      (up_click),
        .down_click    (down_click),
        .temp_setpoint (temp_setpoint),
        .hum_setpoint  (hum_setpoint),
        .edit_value    (edit_value),
        .edit_field    (edit_field),
        .update_strobe (update_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] temp;
        logic [7:0] hum;
        logic [7:0] val;
        logic [1:0] field;
        logic       strobe;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // behavioural model: 0 idle, 1 temperature, 2 humidity
    int m_st, m_wt, m_wh, m_t, m_h, m_cnt;
    bit m_strobe;

    function automatic int sat(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic model_reset();
        m_st = 0; m_wt = 24; m_wh = 60; m_t = 24; m_h = 60; m_cnt = 0; m_strobe = 0;
    endtask

    task automatic model_step(input bit m, input bit u, input bit d);
        m_strobe = 0;
        if (m_st == 0) begin
            if (m) begin m_wt = m_t; m_wh = m_h; m_st = 1; end
            m_cnt = 0;
        end else if (m) begin
            m_cnt = 0;
            if (m_st == 1) m_st = 2;
            else begin m_t = m_wt; m_h = m_wh; m_strobe = 1; m_st = 0; end
        end else if (u || d) begin
            m_cnt = 0;
            if (u != d) begin
                if (m_st == 1) m_wt = sat(m_wt + (u ? 1 : -1), 10, 40);
                else           m_wh = sat(m_wh + (u ? 1 : -1), 20, 90);
            end
        end else if (m_cnt == TO - 1) begin
            if (AUTO) begin m_t = m_wt; m_h = m_wh; m_strobe = 1; end
            m_st = 0; m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag    = tag;
        e.temp   = 8'(m_t);
        e.hum    = 8'(m_h);
        e.val    = (m_st == 1) ? 8'(m_wt) : (m_st == 2) ? 8'(m_wh) : 8'd0;
        e.field  = 2'(m_st);
        e.strobe = m_strobe;
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty: observed=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            check({e.tag, ".temp"},   {24'd0, temp_setpoint}, {24'd0, e.temp});
            check({e.tag, ".hum"},    {24'd0, hum_setpoint},  {24'd0, e.hum});
            check({e.tag, ".value"},  {24'd0, edit_value},    {24'd0, e.val});
            check({e.tag, ".field"},  {30'd0, edit_field},    {30'd0, e.field});
            check({e.tag, ".strobe"}, {31'd0, update_strobe}, {31'd0, e.strobe});
        end
    endtask

    // one clock with the given clicks held across the edge, then compare #1 after it
    task automatic cyc(input bit m, input bit u, input bit d, input string tag);
        mode_click = m; up_click = u; down_click = d;
        model_step(m, u, d);
        push_exp(tag);
        @(posedge clk);
        #1;
        mode_click = 1'b0; up_click = 1'b0; down_click = 1'b0;
        pop_check();
    endtask

    task automatic repeat_cyc(input int n, input bit m, input bit u, input bit d, input string tag);
        for (int i = 0; i < n; i++) cyc(m, u, d, tag);
    endtask

    initial begin
        rst_n = 1'b0; mode_click = 1'b0; up_click = 1'b0; down_click = 1'b0;
        model_reset();
        #12;
        push_exp("reset");
        pop_check();
        @(negedge clk);
        rst_n = 1'b1;

        repeat_cyc(3, 0, 1, 0, "idle_up");

        cyc(1, 0, 0, "edit_mode1");
        repeat_cyc(2, 0, 1, 0, "edit_up");
        cyc(1, 0, 0, "edit_mode2");
        repeat_cyc(5, 0, 0, 1, "edit_down");
        cyc(1, 0, 0, "edit_commit");
        check("commit_temp_26", {24'd0, temp_setpoint}, 32'd26);
        check("commit_hum_55",  {24'd0, hum_setpoint},  32'd55);
        check("commit_strobe",  {31'd0, update_strobe}, 32'd1);
        cyc(0, 0, 0, "post_commit");

        cyc(1, 0, 0, "sat_enter");
        repeat_cyc(20, 0, 1, 0, "sat_up");
        check("sat_temp_max", {24'd0, edit_value}, 32'd40);
        cyc(1, 0, 0, "sat_to_hum");
        repeat_cyc(50, 0, 0, 1, "sat_down");
        check("sat_hum_min", {24'd0, edit_value}, 32'd20);
        cyc(1, 0, 0, "sat_commit");

        cyc(1, 0, 0, "sim_enter");
        cyc(0, 0, 1, "sim_down");
        cyc(0, 1, 1, "sim_updown");
        check("sim_updown_hold", {24'd0, edit_value}, 32'd39);
        cyc(1, 1, 0, "sim_mode_up");
        check("sim_mode_up_field", {30'd0, edit_field}, 32'd2);
        cyc(1, 0, 0, "sim_commit");
        check("sim_temp_kept", {24'd0, temp_setpoint}, 32'd39);

        cyc(1, 0, 0, "rst_enter");
        cyc(0, 1, 0, "rst_up_t");
        cyc(1, 0, 0, "rst_to_hum");
        repeat_cyc(2, 0, 1, 0, "rst_up_h");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        push_exp("mid_reset");
        pop_check();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, "after_reset");

        cyc(1, 0, 0, "to_enter");
        cyc(0, 1, 0, "to_up");
        repeat_cyc(TO - 1, 0, 0, 0, "to_wait");
        check("to_still_editing", {30'd0, edit_field}, 32'd1);
        cyc(0, 0, 0, "to_expire");
        check("to_field_none", {30'd0, edit_field}, 32'd0);
        check("to_temp", {24'd0, temp_setpoint}, AUTO ? 32'd25 : 32'd24);
        repeat_cyc(3, 0, 0, 0, "to_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
